// File: rtl/fp_seq_pkg.sv
// Shared constants and types for the RV32F issue sequencer: funct5 codes,
// sign-injection variants, FSM state encoding and fflags bit positions.
package fp_seq_pkg;

  localparam logic [4:0] F5_FADD  = 5'b00000;
  localparam logic [4:0] F5_FSUB  = 5'b00001;
  localparam logic [4:0] F5_FMUL  = 5'b00010;
  localparam logic [4:0] F5_FDIV  = 5'b00011;
  localparam logic [4:0] F5_SGNJ  = 5'b00100;
  localparam logic [4:0] F5_FSQRT = 5'b01011;

  localparam logic [2:0] RM_SGNJ  = 3'b000;
  localparam logic [2:0] RM_SGNJN = 3'b001;
  localparam logic [2:0] RM_SGNJX = 3'b010;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } seq_state_e;

  function automatic logic is_fpu_funct5(input logic [4:0] f5);
    return (f5 == F5_FADD) || (f5 == F5_FSUB) || (f5 == F5_FMUL) ||
           (f5 == F5_FDIV) || (f5 == F5_FSQRT);
  endfunction

  function automatic logic is_sgnj_op(input logic [4:0] f5, input logic [2:0] rm);
    return (f5 == F5_SGNJ) &&
           ((rm == RM_SGNJ) || (rm == RM_SGNJN) || (rm == RM_SGNJX));
  endfunction

endpackage

// File: rtl/fp_sgnj_unit.sv
// Combinational RV32F sign injection: magnitude from a, sign selected by rm.
module fp_sgnj_unit
  import fp_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rm,
  output logic [31:0] result
);

  logic sign;
  logic unused_b;

  always_comb begin
    case (rm)
      RM_SGNJN: sign = ~b[31];
      RM_SGNJX: sign = a[31] ^ b[31];
      default:  sign = b[31];
    endcase
  end

  assign result   = {sign, a[30:0]};
  assign unused_b = ^b[30:0];

endmodule

// File: rtl/fpu_issue_sequencer.sv
// Issues RV32F arithmetic ops to an external multi-cycle FPU, stalls the core
// until writeback, runs sign injection locally and accrues sticky fflags.
// Optional WAIT watchdog: define FPU_SEQ_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for an FP op in decode; accepts and stalls combinationally
// ISSUE | fpu_start pulse, operands held stable
// WAIT  | waiting for fpu_done (or watchdog expiry)
// WB    | FP regfile write, core released, fflags accrue
module fpu_issue_sequencer
  import fp_seq_pkg::*;
#(
  parameter int FLEN        = 32,
  parameter int WDOG_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_fp_valid,
  input  logic [4:0]      id_funct5,
  input  logic [2:0]      id_rm,
  input  logic [4:0]      id_rd,
  input  logic [FLEN-1:0] id_rs1_data,
  input  logic [FLEN-1:0] id_rs2_data,
  output logic            core_stall,
  output logic            fpu_start,
  output logic [4:0]      fpu_op,
  output logic [2:0]      fpu_rm,
  output logic [FLEN-1:0] fpu_a,
  output logic [FLEN-1:0] fpu_b,
  input  logic            fpu_done,
  input  logic [FLEN-1:0] fpu_result,
  input  logic [4:0]      fpu_flags,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [FLEN-1:0] wb_data,
  output logic [4:0]      fflags,
  input  logic            fflags_clr,
  output logic            illegal_op,
  output logic            fpu_timeout
);

  seq_state_e state_q, state_d;

  logic [4:0]      op_q, op_d;
  logic [2:0]      rm_q, rm_d;
  logic [4:0]      rd_q, rd_d;
  logic [FLEN-1:0] a_q, a_d;
  logic [FLEN-1:0] b_q, b_d;
  logic [FLEN-1:0] result_q, result_d;
  logic [4:0]      flags_q, flags_d;
  logic [4:0]      fflags_q, fflags_d;

  logic            accept_fpu;
  logic            accept_sgnj;
  logic            wdog_expire;
  logic [FLEN-1:0] sgnj_result;

  assign accept_fpu  = (state_q == ST_IDLE) && id_fp_valid && is_fpu_funct5(id_funct5);
  assign accept_sgnj = (state_q == ST_IDLE) && id_fp_valid && is_sgnj_op(id_funct5, id_rm);

  fp_sgnj_unit u_sgnj (
    .a      (id_rs1_data),
    .b      (id_rs2_data),
    .rm     (id_rm),
    .result (sgnj_result)
  );

`ifdef FPU_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES) + 1;

  logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           timeout_q;

  assign wdog_expire = (state_q == ST_WAIT) && !fpu_done && (wdog_cnt_q == '0);

  // Loaded in ISSUE so WAIT lasts exactly WDOG_CYCLES cycles before expiry.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (state_q == ST_ISSUE)
      wdog_cnt_d = WDW'(WDOG_CYCLES - 1);
    else if ((state_q == ST_WAIT) && (wdog_cnt_q != '0))
      wdog_cnt_d = wdog_cnt_q - WDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      timeout_q  <= wdog_expire;
    end
  end

  assign fpu_timeout = timeout_q;
`else
  logic unused_wdog;

  assign wdog_expire = 1'b0;
  assign fpu_timeout = 1'b0;
  assign unused_wdog = (WDOG_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_fpu)       state_d = ST_ISSUE;
        else if (accept_sgnj) state_d = ST_WB;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (fpu_done || wdog_expire) state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    core_stall = 1'b0;
    fpu_start  = 1'b0;
    wb_en      = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_IDLE: begin
        core_stall = accept_fpu || accept_sgnj;
        illegal_op = id_fp_valid && !accept_fpu && !accept_sgnj;
      end
      ST_ISSUE: begin
        core_stall = 1'b1;
        fpu_start  = 1'b1;
      end
      ST_WAIT:  core_stall = 1'b1;
      ST_WB:    wb_en = 1'b1;
      default:  core_stall = 1'b0;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    rm_d     = rm_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;

    if (accept_fpu) begin
      op_d = id_funct5;
      rm_d = id_rm;
      rd_d = id_rd;
      a_d  = id_rs1_data;
      b_d  = id_rs2_data;
    end else if (accept_sgnj) begin
      rd_d     = id_rd;
      result_d = sgnj_result;
      flags_d  = '0;
    end else if ((state_q == ST_WAIT) && fpu_done) begin
      result_d = fpu_result;
      flags_d  = fpu_flags;
    end else if (wdog_expire) begin
      result_d       = CANON_NAN;
      flags_d        = '0;
      flags_d[FF_NV] = 1'b1;
    end

    // A clear coinciding with writeback drops the old flags but keeps the new.
    fflags_d = fflags_clr ? 5'b0 : fflags_q;
    if (state_q == ST_WB)
      fflags_d = fflags_d | flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      fflags_q <= '0;
    end else begin
      op_q     <= op_d;
      rm_q     <= rm_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      fflags_q <= fflags_d;
    end
  end

  assign fpu_op  = op_q;
  assign fpu_rm  = rm_q;
  assign fpu_a   = a_q;
  assign fpu_b   = b_q;
  assign wb_rd   = rd_q;
  assign wb_data = result_q;
  assign fflags  = fflags_q;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed bench for fpu_issue_sequencer with a cycle-scheduled FPU response.
module tb_fpu_issue_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_fp_valid;
  logic [4:0]  id_funct5;
  logic [2:0]  id_rm;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        core_stall;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        illegal_op;
  logic        fpu_timeout;

  int checks = 0;
  int errors = 0;
  int to_cnt = 0;

  fpu_issue_sequencer #(.FLEN(32), .WDOG_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_fp_valid (id_fp_valid),
    .id_funct5   (id_funct5),
    .id_rm       (id_rm),
    .id_rd       (id_rd),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .core_stall  (core_stall),
    .fpu_start   (fpu_start),
    .fpu_op      (fpu_op),
    .fpu_rm      (fpu_rm),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_done    (fpu_done),
    .fpu_result  (fpu_result),
    .fpu_flags   (fpu_flags),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .fflags      (fflags),
    .fflags_clr  (fflags_clr),
    .illegal_op  (illegal_op),
    .fpu_timeout (fpu_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fpu_timeout === 1'b1) to_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".stall"},   core_stall,  0);
    check_eq({tag, ".start"},   fpu_start,   0);
    check_eq({tag, ".op"},      fpu_op,      0);
    check_eq({tag, ".rm"},      fpu_rm,      0);
    check_eq({tag, ".a"},       fpu_a,       0);
    check_eq({tag, ".b"},       fpu_b,       0);
    check_eq({tag, ".wb_en"},   wb_en,       0);
    check_eq({tag, ".wb_rd"},   wb_rd,       0);
    check_eq({tag, ".wb_data"}, wb_data,     0);
    check_eq({tag, ".fflags"},  fflags,      0);
    check_eq({tag, ".illegal"}, illegal_op,  0);
    check_eq({tag, ".timeout"}, fpu_timeout, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Accept on cycle 0, ISSUE on 1, fpu_done on 1+lat, WB on 2+lat.
  task automatic run_fpu(input string tag, input logic [4:0] f5, input logic [2:0] rm,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] res, input logic [4:0] fl,
                         input bit clr_wb);
    for (int c = 0; c <= lat + 3; c++) begin
      id_fp_valid = (c == 0);
      id_funct5   = f5;
      id_rm       = rm;
      id_rd       = rd;
      id_rs1_data = a;
      id_rs2_data = b;
      fpu_done    = (c == lat + 1);
      fpu_result  = (c == lat + 1) ? res : 32'hDEAD_BEEF;
      fpu_flags   = (c == lat + 1) ? fl : 5'h1F;
      fflags_clr  = clr_wb && (c == lat + 2);
      @(negedge clk);
      check_eq($sformatf("%s.stall@%0d", tag, c), core_stall, (c <= lat + 1));
      check_eq($sformatf("%s.start@%0d", tag, c), fpu_start, (c == 1));
      check_eq($sformatf("%s.wb_en@%0d", tag, c), wb_en, (c == lat + 2));
      check_eq($sformatf("%s.illegal@%0d", tag, c), illegal_op, 0);
      if (c >= 1 && c <= lat + 1) begin
        check_eq($sformatf("%s.fpu_op@%0d", tag, c), fpu_op, f5);
        check_eq($sformatf("%s.fpu_rm@%0d", tag, c), fpu_rm, rm);
        check_eq($sformatf("%s.fpu_a@%0d", tag, c), fpu_a, a);
        check_eq($sformatf("%s.fpu_b@%0d", tag, c), fpu_b, b);
      end
      if (c == lat + 2) begin
        check_eq({tag, ".wb_rd"}, wb_rd, rd);
        check_eq({tag, ".wb_data"}, wb_data, res);
      end
      next_cycle();
    end
    id_fp_valid = 1'b0;
    fpu_done    = 1'b0;
    fflags_clr  = 1'b0;
  endtask

  task automatic run_sgnj(input string tag, input logic [2:0] rm, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    for (int c = 0; c <= 2; c++) begin
      id_fp_valid = (c == 0);
      id_funct5   = 5'b00100;
      id_rm       = rm;
      id_rd       = rd;
      id_rs1_data = a;
      id_rs2_data = b;
      @(negedge clk);
      check_eq($sformatf("%s.stall@%0d", tag, c), core_stall, (c == 0));
      check_eq($sformatf("%s.start@%0d", tag, c), fpu_start, 0);
      check_eq($sformatf("%s.wb_en@%0d", tag, c), wb_en, (c == 1));
      if (c == 1) begin
        check_eq({tag, ".wb_rd"}, wb_rd, rd);
        check_eq({tag, ".wb_data"}, wb_data, exp);
      end
      next_cycle();
    end
    id_fp_valid = 1'b0;
  endtask

  task automatic run_illegal(input string tag, input logic [4:0] f5, input logic [2:0] rm);
    for (int c = 0; c <= 1; c++) begin
      id_fp_valid = (c == 0);
      id_funct5   = f5;
      id_rm       = rm;
      id_rd       = 5'd3;
      @(negedge clk);
      check_eq($sformatf("%s.illegal@%0d", tag, c), illegal_op, (c == 0));
      check_eq($sformatf("%s.stall@%0d", tag, c), core_stall, 0);
      check_eq($sformatf("%s.wb_en@%0d", tag, c), wb_en, 0);
      check_eq($sformatf("%s.start@%0d", tag, c), fpu_start, 0);
      next_cycle();
    end
    id_fp_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    id_fp_valid = 1'b0;
    id_funct5   = '0;
    id_rm       = '0;
    id_rd       = '0;
    id_rs1_data = '0;
    id_rs2_data = '0;
    fpu_done    = 1'b0;
    fpu_result  = '0;
    fpu_flags   = '0;
    fflags_clr  = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    run_fpu("fadd", 5'b00000, 3'b000, 5'd5, 32'h3F80_0000, 32'h4000_0000,
            3, 32'h4040_0000, 5'b00000, 1'b0);
    check_eq("fadd.fflags", fflags, 5'b00000);

    run_fpu("fsqrt_l1", 5'b01011, 3'b001, 5'd12, 32'h4080_0000, 32'h0000_0000,
            1, 32'h4000_0000, 5'b00000, 1'b0);

    run_sgnj("sgnjn", 3'b001, 5'd7, 32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000);
    run_sgnj("sgnj",  3'b000, 5'd8, 32'h3F80_0000, 32'h8000_0000, 32'hBF80_0000);
    run_sgnj("sgnjx", 3'b010, 5'd9, 32'hBF80_0000, 32'hC000_0000, 32'h3F80_0000);
    check_eq("sgnj.fflags", fflags, 5'b00000);

    run_illegal("ill_f5", 5'b11111, 3'b000);
    run_illegal("ill_rm", 5'b00100, 3'b011);

    run_fpu("fdiv", 5'b00011, 3'b000, 5'd1, 32'h3F80_0000, 32'h0000_0000,
            2, 32'h7F80_0000, 5'b01000, 1'b0);
    check_eq("fdiv.fflags", fflags, 5'b01000);
    run_fpu("fmul", 5'b00010, 3'b011, 5'd2, 32'h4000_0000, 32'h4000_0000,
            4, 32'h4080_0000, 5'b00001, 1'b0);
    check_eq("fmul.fflags", fflags, 5'b01001);
    run_fpu("fmul_clr", 5'b00010, 3'b000, 5'd4, 32'h3F00_0000, 32'h3F00_0000,
            2, 32'h3E80_0000, 5'b00001, 1'b1);
    check_eq("clr_wb.fflags", fflags, 5'b00001);

    fflags_clr = 1'b1;
    next_cycle();
    fflags_clr = 1'b0;
    check_eq("clr_idle.fflags", fflags, 5'b00000);

    run_fpu("fsub_flag", 5'b00001, 3'b000, 5'd6, 32'h4000_0000, 32'h3F80_0000,
            2, 32'h3F80_0000, 5'b00100, 1'b0);
    check_eq("fsub.fflags", fflags, 5'b00100);

    // Abandon an in-flight op with reset during WAIT.
    id_fp_valid = 1'b1;
    id_funct5   = 5'b00001;
    id_rm       = 3'b010;
    id_rd       = 5'd9;
    id_rs1_data = 32'h1234_5678;
    id_rs2_data = 32'h9ABC_DEF0;
    next_cycle();
    id_fp_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("prerst.stall", core_stall, 1);
    check_eq("prerst.fpu_a", fpu_a, 32'h1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    #2;
    rst_n = 1'b1;
    next_cycle();
    fpu_done   = 1'b1;
    fpu_result = 32'h4040_0000;
    fpu_flags  = 5'b11111;
    @(negedge clk);
    check_eq("late_done.wb_en", wb_en, 0);
    check_eq("late_done.stall", core_stall, 0);
    next_cycle();
    fpu_done = 1'b0;
    @(negedge clk);
    check_eq("late_done.wb_en2", wb_en, 0);
    check_eq("late_done.fflags", fflags, 5'b00000);
    check_eq("late_done.wb_data", wb_data, 32'h0);
    next_cycle();

`ifdef FPU_SEQ_WATCHDOG_EN
    // Accept c0, ISSUE c1, WAIT c2..c9, forced WB with timeout on c10.
    for (int c = 0; c <= 11; c++) begin
      id_fp_valid = (c == 0);
      id_funct5   = 5'b00011;
      id_rm       = 3'b000;
      id_rd       = 5'd11;
      id_rs1_data = 32'h3F80_0000;
      id_rs2_data = 32'h4000_0000;
      fpu_done    = 1'b0;
      @(negedge clk);
      check_eq($sformatf("wdog.stall@%0d", c), core_stall, (c <= 9));
      check_eq($sformatf("wdog.wb_en@%0d", c), wb_en, (c == 10));
      check_eq($sformatf("wdog.timeout@%0d", c), fpu_timeout, (c == 10));
      if (c == 10) begin
        check_eq("wdog.wb_rd", wb_rd, 5'd11);
        check_eq("wdog.wb_data", wb_data, 32'h7FC0_0000);
      end
      next_cycle();
    end
    id_fp_valid = 1'b0;
    check_eq("wdog.fflags", fflags, 5'b10000);
    fpu_done   = 1'b1;
    fpu_result = 32'h1111_1111;
    fpu_flags  = 5'b00001;
    next_cycle();
    fpu_done = 1'b0;
    @(negedge clk);
    check_eq("wdog.late_wb_en", wb_en, 0);
    check_eq("wdog.late_fflags", fflags, 5'b10000);
    check_eq("wdog.timeout_count", to_cnt, 1);
`else
    check_eq("no_timeout_count", to_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
